seg_value_encoder: RTL and testbench

Converts a 7-bit binary value (0–99) into the two-digit seven-segment word `both7seg[13:0]` consumed by the downstream two-digit segment multiplexer. Binary-to-BCD conversion is iterative (shift-and-add-3, one bit per cycle), followed by a registered segment-encode stage. Output is held stable between conversions, so the multiplexer samples it at any time.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seven_seg_digit.sv | 27 ++
 rtl/seg_value_encoder.sv | 107 ++++++++++
 tb/tb_seg_value_encoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the two-digit seven-segment value encoder.
// Segment bit order is g,f,e,d,c,b,a (bit 6 = g), active-high.
package seg_pkg;

    localparam int         VAL_WIDTH = 7;
    localparam logic [6:0] MAX_VAL   = 7'd99;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } state_t;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after the next doubling.
    function automatic logic [3:0] bcd_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/seven_seg_digit.sv
// Combinational BCD digit to seven-segment decoder; non-decimal nibbles show nothing.
module seven_seg_digit
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_value_encoder.sv
// Binary (0-99) to two-digit seven-segment word: iterative shift-and-add-3 BCD
// conversion followed by a registered encode stage; the output holds between conversions.
module seg_value_encoder
    import seg_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1,
    parameter int VAL_W    = VAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] value,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [13:0]      both7seg
);

    state_t           state_r;
    logic [VAL_W-1:0] shift_r;
    logic [7:0]       bcd_r;
    logic [2:0]       cnt_r;
    logic             ovr_r;
    logic             busy_r;
    logic             done_r;
    logic [13:0]      seg_r;
    logic [6:0]       tens_seg_s;
    logic [6:0]       ones_seg_s;
    logic [13:0]      next_seg_s;

    seven_seg_digit u_tens (
        .digit (bcd_r[7:4]),
        .seg   (tens_seg_s)
    );

    seven_seg_digit u_ones (
        .digit (bcd_r[3:0]),
        .seg   (ones_seg_s)
    );

    // Output word selection: overflow dashes win over leading-zero blanking
    always_comb begin
        next_seg_s = {SEG_BLANK, SEG_BLANK};
        if (ovr_r) begin
            next_seg_s = {SEG_DASH, SEG_DASH};
        end else if (BLANK_LZ && (bcd_r[7:4] == 4'd0)) begin
            next_seg_s = {SEG_BLANK, ones_seg_s};
        end else begin
            next_seg_s = {tens_seg_s, ones_seg_s};
        end
    end

    // Conversion FSM, shift/BCD datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            shift_r <= '0;
            bcd_r   <= 8'd0;
            cnt_r   <= 3'd0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            seg_r   <= 14'h0000;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shift_r <= value;
                        bcd_r   <= 8'd0;
                        cnt_r   <= 3'd0;
                        ovr_r   <= (value > MAX_VAL);
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // Carry out of the tens nibble only occurs for values above 99, which display dashes.
                    {bcd_r, shift_r} <= {bcd_adj(bcd_r[7:4]), bcd_adj(bcd_r[3:0]), shift_r} << 1;
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'd6) begin
                        state_r <= ST_ENCODE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_ENCODE: begin
                    seg_r   <= next_seg_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign both7seg = seg_r;

endmodule

// File: tb/tb_seg_value_encoder.sv
// Randomized self-checking bench: two encoders (blanking on/off) compared every cycle
// against a decimal-arithmetic reference, plus directed scenarios with literal expectations.
module tb_seg_value_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  value = 7'd0;
    logic        start = 1'b0;
    logic        busy0, done0, busy1, done1;
    logic [13:0] seg0, seg1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_value_encoder #(.BLANK_LZ(1'b1), .VAL_W(7)) dut0 (
        .clk(clk), .rst(rst), .value(value), .start(start),
        .busy(busy0), .done(done0), .both7seg(seg0)
    );

    seg_value_encoder #(.BLANK_LZ(1'b0), .VAL_W(7)) dut1 (
        .clk(clk), .rst(rst), .value(value), .start(start),
        .busy(busy1), .done(done1), .both7seg(seg1)
    );

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [13:0] expect_word(input int v, input bit blank);
        int t;
        int o;
        if (v > 99) return {7'h40, 7'h40};
        t = v / 10;
        o = v % 10;
        if (blank && t == 0) return {7'h00, seg_tbl[o]};
        return {seg_tbl[t], seg_tbl[o]};
    endfunction

    task automatic check_w(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion takes 8 edges after acceptance, starts ignored meanwhile.
    int          m_rem = 0;
    int          m_val = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [13:0] m_seg0 = 14'h0000;
    logic [13:0] m_seg1 = 14'h0000;
    bit          check_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_rem = 0; m_busy = 1'b0; m_done = 1'b0;
            m_seg0 = 14'h0000; m_seg1 = 14'h0000;
            check_en = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_rem != 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_seg0 = expect_word(m_val, 1'b1);
                    m_seg1 = expect_word(m_val, 1'b0);
                end
            end else if (start) begin
                m_val  = int'(value);
                m_rem  = 8;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_w("seg_blank", seg0, m_seg0);
            check_w("seg_noblank", seg1, m_seg1);
            check_b("busy_blank", busy0, m_busy);
            check_b("busy_noblank", busy1, m_busy);
            check_b("done_blank", done0, m_done);
            check_b("done_noblank", done1, m_done);
        end
    end

    // Start one conversion from a negedge; returns cycles from accept edge to done.
    task automatic run(input logic [6:0] v, output int lat);
        int n;
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        lat = n - 1;
        check_b("done_seen", done0, 1'b1);
    endtask

    initial begin
        int lat;
        int ndone;
        int gap;

        rst = 1'b0; start = 1'b1; value = 7'd42;
        repeat (3) @(negedge clk);
        check_w("reset_seg", seg0, 14'h0000);
        check_b("reset_busy", busy0, 1'b0);
        check_b("reset_done", done0, 1'b0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        run(7'd42, lat);
        check_i("latency_42", lat, 8);
        check_w("val_42", seg0, {7'h66, 7'h5B});
        run(7'd0, lat);
        check_w("val_0", seg0, {7'h00, 7'h3F});
        run(7'd7, lat);
        check_w("val_7_blank", seg0, {7'h00, 7'h07});
        check_w("val_7_noblank", seg1, {7'h3F, 7'h07});
        run(7'd99, lat);
        check_w("val_99", seg0, {7'h6F, 7'h6F});
        run(7'd100, lat);
        check_i("latency_100", lat, 8);
        check_w("val_100", seg0, {7'h40, 7'h40});
        run(7'd127, lat);
        check_i("latency_127", lat, 8);
        check_w("val_127", seg1, {7'h40, 7'h40});

        // Start during busy is ignored
        value = 7'd42; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); value = 7'd13; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        check_i("busy_reject_dones", ndone, 1);
        check_w("busy_reject_val", seg0, {7'h66, 7'h5B});

        // Held start re-accepted right after done
        value = 7'd25; start = 1'b1;
        gap = 0;
        do begin @(negedge clk); gap++; end while (!done0 && gap < 30);
        check_w("cont_first", seg0, {7'h5B, 7'h6D});
        value = 7'd31;
        gap = 0;
        do begin @(negedge clk); gap++; end while (!done0 && gap < 30);
        check_i("cont_period", gap, 9);
        check_w("cont_second", seg0, {7'h4F, 7'h06});
        start = 1'b0;
        @(negedge clk);

        // Reset mid-conversion
        value = 7'd88; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_w("midreset_seg", seg0, 14'h0000);
        check_b("midreset_busy", busy0, 1'b0);
        check_b("midreset_done", done0, 1'b0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        run(7'd56, lat);
        check_w("val_56", seg0, {7'h6D, 7'h7D});

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            value = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 127))
                                                : 7'($urandom_range(95, 104));
            rst   = ($urandom_range(0, 199) != 0);
        end
        rst = 1'b1; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
